bus_arbiter8: RTL and testbench

- Round-robin arbiter and sequencer that shares one 16-bit output bus among 8 requesters.
- The datapath is the existing Mux8Way16; this block owns its 3-bit select and gates the mux output with a valid/ready handshake.
- It sits between eight word producers (register file ports, I/O, debug) and a single downstream consumer.

---
 rtl/bus_arbiter8_pkg.sv | 34 +++
 rtl/Mux8Way16.sv | 34 +++
 rtl/bus_arbiter8.sv | 107 ++++++++++
 tb/tb_bus_arbiter8.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arbiter8_pkg : shared constants, FSM states, round-robin picker   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bus_arbiter8_pkg;

    localparam int N_REQ  = 8;
    localparam int WORD_W = 16;
    localparam int SEL_W  = 3;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_t;

    // The scan starts just after LAST and ends on LAST, so LAST has the lowest priority.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                                 input logic [SEL_W-1:0] last_v);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last_v;
        found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last_v + SEL_W'(k);
            if (!found && req_v[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/Mux8Way16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Mux8Way16 : 8-to-1 multiplexer of 16-bit words                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module Mux8Way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        out = a;
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            default: out = h;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arbiter8 : round-robin arbiter sharing one 16-bit bus among 8     |
// | requesters with a valid/ready handshake.   Revision: 1.0              |
// +----------------------------------------------------------------------+
module bus_arbiter8
    import bus_arbiter8_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] data,
    input  logic                    out_ready,
    output logic [WORD_W-1:0]       out,
    output logic                    out_valid,
    output logic [N_REQ-1:0]        grant,
    output logic [SEL_W-1:0]        sel,
    output logic [15:0]             xfer_count
);

    state_t             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   last_q;
    logic [N_REQ-1:0]   grant_q;
    logic               out_valid_q;
    logic [15:0]        xfer_count_q;
    logic [15:0]        xfer_count_d;

    logic [SEL_W-1:0]   pick_w;
    logic               any_req_w;
    logic               accept_w;
    logic               release_w;
    logic [WORD_W-1:0]  out_raw_w;

    assign pick_w       = rr_pick(req, last_q);
    assign any_req_w    = |req;
    assign accept_w     = out_valid_q & out_ready;
    // Either an accept or a withdrawal by the current owner frees the bus.
    assign release_w    = accept_w | ~req[sel_q];
    assign xfer_count_d = xfer_count_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= STATE_IDLE;
            sel_q        <= '0;
            last_q       <= SEL_W'(N_REQ - 1);
            grant_q      <= '0;
            out_valid_q  <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    if (any_req_w) begin
                        state_q     <= STATE_BUSY;
                        sel_q       <= pick_w;
                        last_q      <= pick_w;
                        grant_q     <= N_REQ'(1) << pick_w;
                        out_valid_q <= 1'b1;
                    end
                end
                STATE_BUSY: begin
                    if (accept_w) begin
                        xfer_count_q <= xfer_count_d;
                    end
                    if (release_w) begin
                        if (any_req_w) begin
                            sel_q       <= pick_w;
                            last_q      <= pick_w;
                            grant_q     <= N_REQ'(1) << pick_w;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q     <= STATE_IDLE;
                            grant_q     <= '0;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= STATE_IDLE;
                    grant_q     <= '0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    Mux8Way16 u_mux (
        .a   (data[0*WORD_W +: WORD_W]),
        .b   (data[1*WORD_W +: WORD_W]),
        .c   (data[2*WORD_W +: WORD_W]),
        .d   (data[3*WORD_W +: WORD_W]),
        .e   (data[4*WORD_W +: WORD_W]),
        .f   (data[5*WORD_W +: WORD_W]),
        .g   (data[6*WORD_W +: WORD_W]),
        .h   (data[7*WORD_W +: WORD_W]),
        .sel (sel_q),
        .out (out_raw_w)
    );

    assign out        = out_raw_w & {WORD_W{out_valid_q}};
    assign out_valid  = out_valid_q;
    assign grant      = grant_q;
    assign sel        = sel_q;
    assign xfer_count = xfer_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_arbiter8 : directed and random checks against a reference model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bus_arbiter8;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   req;
    logic [127:0] data;
    logic         out_ready;
    logic [15:0]  out;
    logic         out_valid;
    logic [7:0]   grant;
    logic [2:0]   sel;
    logic [15:0]  xfer_count;

    int total = 0;
    int bad   = 0;

    // reference state
    bit          m_known = 0;
    bit          m_busy;
    int          m_sel;
    int          m_last;
    logic [15:0] m_count;

    bus_arbiter8 dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data       (data),
        .out_ready  (out_ready),
        .out        (out),
        .out_valid  (out_valid),
        .grant      (grant),
        .sel        (sel),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic int ref_pick(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    task automatic check_model();
        logic [7:0]  eg;
        logic [15:0] eo;
        eg = m_busy ? 8'(1 << m_sel) : 8'h00;
        eo = m_busy ? data[16*m_sel +: 16] : 16'h0000;
        chk("valid", {31'b0, out_valid}, {31'b0, m_busy});
        chk("grant", {24'b0, grant}, {24'b0, eg});
        chk("out",   {16'b0, out}, {16'b0, eo});
        chk("count", {16'b0, xfer_count}, {16'b0, m_count});
        if (m_busy) chk("sel", {29'b0, sel}, 32'(m_sel));
    endtask

    task automatic step(input logic rst_v, input logic [7:0] r, input logic rdy);
        int p;
        reset = rst_v; req = r; out_ready = rdy;
        #1;
        if (m_known) check_model();
        @(posedge clk);
        if (rst_v) begin
            m_known = 1; m_busy = 0; m_sel = 0; m_last = 7; m_count = 16'h0;
        end else if (m_known) begin
            p = ref_pick(r, m_last);
            if (!m_busy) begin
                if (p >= 0) begin m_busy = 1; m_sel = p; m_last = p; end
            end else begin
                if (rdy) m_count = m_count + 16'd1;
                if (rdy || !r[m_sel]) begin
                    if (p >= 0) begin m_sel = p; m_last = p; end
                    else m_busy = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; req = '0; data = '0; out_ready = 1'b0;

        // reset state
        step(1, 8'h00, 0);
        step(1, 8'h00, 0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_grant", {24'b0, grant}, 32'h0);
        chk("rst_sel",   {29'b0, sel}, 32'h0);
        chk("rst_count", {16'b0, xfer_count}, 32'h0);

        // single requester
        data[2*16 +: 16] = 16'h5358;
        step(0, 8'h04, 1);
        chk("single_grant", {24'b0, grant}, 32'h04);
        chk("single_sel",   {29'b0, sel}, 32'h2);
        chk("single_out",   {16'b0, out}, 32'h5358);
        step(0, 8'h00, 1);
        chk("single_idle",  {31'b0, out_valid}, 32'h0);
        chk("single_count", {16'b0, xfer_count}, 32'h1);

        // all requesters, back-to-back
        data = {16'h2795, 16'h3383, 16'h6264, 16'h2384, 16'h9793, 16'h5358, 16'h5926, 16'h3141};
        step(1, 8'h00, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 8'hFF, 1);
            chk("rr_sel",   {29'b0, sel}, 32'(i % 8));
            chk("rr_valid", {31'b0, out_valid}, 32'h1);
        end
        chk("rr_count", {16'b0, xfer_count}, 32'h8);

        // stall on requester 3
        step(1, 8'h00, 0);
        for (int i = 0; i < 6; i++) step(0, 8'h08, 0);
        chk("stall_sel",   {29'b0, sel}, 32'h3);
        chk("stall_out",   {16'b0, out}, 32'h9793);
        chk("stall_count", {16'b0, xfer_count}, 32'h0);
        step(0, 8'h00, 1);
        chk("stall_acc",   {16'b0, xfer_count}, 32'h1);

        // priority rotation with last=5
        step(1, 8'h00, 0);
        step(0, 8'h20, 0);
        step(0, 8'h00, 1);
        step(0, 8'h21, 0);
        chk("rot_first",  {29'b0, sel}, 32'h0);
        step(0, 8'h21, 1);
        chk("rot_second", {29'b0, sel}, 32'h5);

        // withdrawal
        step(1, 8'h00, 0);
        step(0, 8'h40, 0);
        step(0, 8'h02, 0);
        chk("wd_sel",   {29'b0, sel}, 32'h1);
        chk("wd_count", {16'b0, xfer_count}, 32'h0);
        step(0, 8'h00, 0);
        chk("wd_idle",  {31'b0, out_valid}, 32'h0);
        chk("wd_out",   {16'b0, out}, 32'h0);

        // reset mid-transfer
        step(1, 8'h00, 0);
        step(0, 8'h04, 1);
        step(0, 8'h0C, 1);
        step(0, 8'h0C, 0);
        step(1, 8'h0C, 0);
        chk("mid_grant", {24'b0, grant}, 32'h0);
        chk("mid_out",   {16'b0, out}, 32'h0);
        chk("mid_count", {16'b0, xfer_count}, 32'h0);
        step(0, 8'h0C, 0);
        chk("mid_regrant", {29'b0, sel}, 32'h2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            data = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 49) == 0), 8'($urandom & $urandom), 1'($urandom));
        end

        // counter wrap after 65536 accepts
        step(1, 8'h00, 0);
        for (int i = 0; i < 65537; i++) step(0, 8'hFF, 1);
        chk("wrap_count", {16'b0, xfer_count}, 32'h0);
        step(0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
